// File: rtl/hex_7seg_mux_driver_pkg.sv
// Shared types and helpers for the multiplexed 7-segment driver.
package hex_7seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Logical (active-high) segment pattern for a dark digit.
    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Index width for a counter/selector over n items, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_7seg_mux_driver_decoder.sv
// Hex nibble to active-high 7-segment code, {a,b,c,d,e,f,g} with a = MSB.
module hex_7seg_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Combinational glyph lookup.
    always_comb begin
        seg = 7'b000_0000;
        case (nibble)
            4'h0: seg = 7'b111_1110;
            4'h1: seg = 7'b011_0000;
            4'h2: seg = 7'b110_1101;
            4'h3: seg = 7'b111_1001;
            4'h4: seg = 7'b011_0011;
            4'h5: seg = 7'b101_1011;
            4'h6: seg = 7'b101_1111;
            4'h7: seg = 7'b111_0000;
            4'h8: seg = 7'b111_1111;
            4'h9: seg = 7'b111_1011;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b001_1111;
            4'hC: seg = 7'b100_1110;
            4'hD: seg = 7'b011_1101;
            4'hE: seg = 7'b100_1111;
            4'hF: seg = 7'b100_0111;
            default: seg = 7'b000_0000;
        endcase
    end

endmodule

// File: rtl/hex_7seg_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with ghost blanking and
// frame-synchronous value updates.
// Optional build macro HEX_7SEG_LZS_EN: leading-zero suppression applied
// when a new value is committed to the active copy.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | scan disabled, anodes off, slot counter and digit index at 0
// BLANK | first BLANK_CYCLES of a slot, anodes off to hide ghosting
// DRIVE | rest of the slot, current digit's anode and segments driven
module hex_7seg_mux_driver
    import hex_7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_en,
    input  logic                                 i_load,
    input  logic [4*NUM_DIGITS-1:0]              i_value,
    input  logic [NUM_DIGITS-1:0]                i_dp,
    input  logic [NUM_DIGITS-1:0]                i_blank,
    output logic [6:0]                           o_seg,
    output logic                                 o_dp,
    output logic [NUM_DIGITS-1:0]                o_an,
    output logic [idx_width(NUM_DIGITS)-1:0]     o_digit_idx,
    output logic                                 o_frame_tick
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_INV}};

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] shadow_value, active_value, src_value;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, src_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank, active_blank, src_blank;
    logic [NUM_DIGITS-1:0]   lzs_mask;
    logic                    pending;

    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic                    drive_on;

    // Scan state, slot counter and digit index registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Next-state: the phase of a slot follows directly from the next counter value.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        boundary = 1'b0;
        if (!i_en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            if (state == IDLE) begin
                cnt_n = '0;
                idx_n = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_n = '0;
                if (idx == IDX_LAST) begin
                    idx_n    = '0;
                    boundary = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
            state_n = (cnt_n < BLANK_END) ? BLANK : DRIVE;
        end
    end

    // Value committed at a boundary: a same-cycle load bypasses the shadow.
    always_comb begin
        src_value = i_load ? i_value : shadow_value;
        src_dp    = i_load ? i_dp    : shadow_dp;
        lzs_mask  = '0;
`ifdef HEX_7SEG_LZS_EN
        begin
            logic lzs_nz;
            lzs_nz = 1'b0;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                lzs_nz      = lzs_nz | (src_value[4*k +: 4] != 4'h0);
                lzs_mask[k] = ~lzs_nz;
            end
        end
`endif
        src_blank = (i_load ? i_blank : shadow_blank) | lzs_mask;
    end

    // Shadow capture on load, shadow-to-active transfer only at frame boundaries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            active_value <= '0;
            active_dp    <= '0;
            active_blank <= '0;
            pending      <= 1'b0;
        end else begin
            if (i_load) begin
                shadow_value <= i_value;
                shadow_dp    <= i_dp;
                shadow_blank <= i_blank;
            end
            if (boundary) begin
                if (i_load || pending) begin
                    active_value <= src_value;
                    active_dp    <= src_dp;
                    active_blank <= src_blank;
                end
                pending <= 1'b0;
            end else if (i_load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        cur_nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nibble = active_value[4*k +: 4];
            end
        end
    end

    hex_7seg_decoder u_decoder (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    assign an_onehot = NUM_DIGITS'(1) << idx;
    assign drive_on  = (state == DRIVE) && !active_blank[idx];

    // Registered pins; a blanked digit keeps its slot but stays dark.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_an         <= AN_OFF;
            o_seg        <= SEG_OFF ^ {7{SEG_INV}};
            o_dp         <= SEG_INV;
            o_digit_idx  <= '0;
            o_frame_tick <= 1'b0;
        end else begin
            o_an         <= drive_on ? (an_onehot ^ AN_OFF) : AN_OFF;
            o_seg        <= (drive_on ? dec_seg : SEG_OFF) ^ {7{SEG_INV}};
            o_dp         <= (drive_on & active_dp[idx]) ^ SEG_INV;
            o_digit_idx  <= idx;
            o_frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_7seg_mux_driver.sv
// Self-checking bench for hex_7seg_mux_driver (4 digits, 8-cycle slots,
// 2 blank cycles, active-low pins). Honours HEX_7SEG_LZS_EN in its model.
module tb_hex_7seg_mux_driver;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp    = '0;
    logic [3:0]  blank = '0;

    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_an;
    logic [1:0]  o_digit_idx;
    logic        o_frame_tick;

    int n_vec = 0;
    int n_err = 0;

    // Reference glyphs, active-high {a..g}
    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: scan position within the frame plus active/shadow copies
    logic        m_scan  = 1'b0;
    int          m_pos   = 0;
    logic [15:0] m_val   = '0, m_sval   = '0;
    logic [3:0]  m_dp    = '0, m_sdp    = '0;
    logic [3:0]  m_blank = '0, m_sblank = '0;
    logic        m_pend  = 1'b0;

    logic [14:0] exp_vec;
    wire  [14:0] obs = {o_an, o_seg, o_dp, o_digit_idx, o_frame_tick};

    always #5 clk = ~clk;

    hex_7seg_mux_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_load       (load),
        .i_value      (value),
        .i_dp         (dp),
        .i_blank      (blank),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_an         (o_an),
        .o_digit_idx  (o_digit_idx),
        .o_frame_tick (o_frame_tick)
    );

    function automatic logic [3:0] lzs_ref(input logic [15:0] v);
        logic [3:0] m;
        m = '0;
`ifdef HEX_7SEG_LZS_EN
        for (int k = 1; k < ND; k++)
            if ((v >> (4 * k)) == 16'd0) m[k] = 1'b1;
`endif
        return m;
    endfunction

    task automatic m_reset();
        m_scan = 1'b0; m_pos = 0; m_pend = 1'b0;
        m_val = '0; m_dp = '0; m_blank = '0;
        m_sval = '0; m_sdp = '0; m_sblank = '0;
    endtask

    // One clock: predict the pins from the pre-edge model state, then advance it.
    task automatic step();
        int         dig;
        logic       bnd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; dig = 0;
        if (m_scan) begin
            dig = m_pos / RD;
            if ((m_pos % RD) >= BC && !m_blank[dig]) begin
                e_an  = ~(4'b0001 << dig);
                e_seg = ~seg_tab[m_val[4*dig +: 4]];
                e_dp  = ~m_dp[dig];
            end
        end
        bnd     = m_scan && en && (m_pos == FRAME - 1);
        exp_vec = {e_an, e_seg, e_dp, 2'(dig), bnd};
        if (bnd) begin
            if (load) begin
                m_val = value; m_dp = dp; m_blank = blank | lzs_ref(value);
            end else if (m_pend) begin
                m_val = m_sval; m_dp = m_sdp; m_blank = m_sblank | lzs_ref(m_sval);
            end
            m_pend = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        if (load) begin
            m_sval = value; m_sdp = dp; m_sblank = blank;
        end
        m_pos  = (m_scan && en) ? (m_pos + 1) % FRAME : 0;
        m_scan = en;
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        en = 1'b0; load = 1'b0;
        #10;
        n_vec++; if (o_an !== 4'hF) begin n_err++; $display("FAIL reset_an got %b want 1111", o_an); end
        n_vec++; if (o_seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %b want 1111111", o_seg); end
        n_vec++; if (o_dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b want 1", o_dp); end
        n_vec++; if (o_digit_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", o_digit_idx); end
        n_vec++; if (o_frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", o_frame_tick); end
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL reset_idle got %b want %b", obs, exp_vec); end
        end
    endtask

    task automatic test_basic();
        int  gap;
        logic seen;
        en = 1'b1; value = 16'h1234; dp = '0; blank = '0; load = 1'b1;
        step();
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL basic got %b want %b", obs, exp_vec); end
        load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL basic got %b want %b", obs, exp_vec); end
            seen = o_frame_tick;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL basic_tick_timeout got none want tick"); end
        for (int j = 0; j < RD; j++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL basic got %b want %b", obs, exp_vec); end
            if (j < BC) begin
                n_vec++; if (o_an !== 4'b1111) begin n_err++; $display("FAIL basic_blank got %b want 1111", o_an); end
            end else begin
                n_vec++;
                if ({o_an, o_seg} !== {4'b1110, 7'b1001100}) begin
                    n_err++; $display("FAIL basic_digit4 got %b_%b want 1110_1001100", o_an, o_seg);
                end
            end
        end
        gap = RD; seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step();
            gap++;
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL basic got %b want %b", obs, exp_vec); end
            seen = o_frame_tick;
        end
        n_vec++; if (!seen || gap != FRAME) begin n_err++; $display("FAIL basic_frame_len got %0d want %0d", gap, FRAME); end
    endtask

    task automatic test_midframe_load();
        logic seen;
        for (int i = 0; i < 13; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL midframe got %b want %b", obs, exp_vec); end
        end
        value = 16'hABCD; load = 1'b1;
        step();
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL midframe got %b want %b", obs, exp_vec); end
        load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL midframe got %b want %b", obs, exp_vec); end
            n_vec++; if (o_seg === 7'b1000010) begin n_err++; $display("FAIL midframe_early got %b want old value", o_seg); end
            seen = o_frame_tick;
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL midframe got %b want %b", obs, exp_vec); end
            if (i == BC) begin
                n_vec++; if (o_seg !== 7'b1000010) begin n_err++; $display("FAIL midframe_digitD got %b want 1000010", o_seg); end
            end
        end
    endtask

    task automatic test_blank_dp();
        logic seen;
        value = 16'h5678; blank = 4'b0100; dp = 4'b0001; load = 1'b1;
        step();
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL blank_dp got %b want %b", obs, exp_vec); end
        load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL blank_dp got %b want %b", obs, exp_vec); end
            seen = o_frame_tick;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL blank_dp_timeout got none want tick"); end
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL blank_dp got %b want %b", obs, exp_vec); end
            n_vec++; if (o_an === 4'b1011) begin n_err++; $display("FAIL blank_dp_an2 got %b want not 1011", o_an); end
            n_vec++;
            if ((o_dp === 1'b0) !== (o_an === 4'b1110)) begin
                n_err++; $display("FAIL blank_dp_point got dp=%b an=%b want dp low only with 1110", o_dp, o_an);
            end
        end
    endtask

    task automatic test_load_on_tick();
        for (int i = 0; i < 2 * FRAME && m_pos != FRAME - 1; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL load_tick got %b want %b", obs, exp_vec); end
        end
        value = 16'h0F0F; blank = '0; dp = '0; load = 1'b1;
        step();
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL load_tick got %b want %b", obs, exp_vec); end
        n_vec++; if (o_frame_tick !== 1'b1) begin n_err++; $display("FAIL load_tick_pulse got %b want 1", o_frame_tick); end
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL load_tick got %b want %b", obs, exp_vec); end
            if (i == BC || i == FRAME + BC) begin
                n_vec++;
                if ({o_an, o_seg} !== {4'b1110, 7'b0111000}) begin
                    n_err++; $display("FAIL load_tick_digitF got %b_%b want 1110_0111000", o_an, o_seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        for (int i = 0; i < 2 * FRAME && m_pos != 20; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL rst_mid got %b want %b", obs, exp_vec); end
        end
        n_vec++; if (o_an !== 4'b1011) begin n_err++; $display("FAIL rst_mid_pre got %b want 1011", o_an); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (o_an !== 4'b1111) begin n_err++; $display("FAIL rst_mid_an got %b want 1111", o_an); end
        n_vec++; if (o_seg !== 7'b1111111) begin n_err++; $display("FAIL rst_mid_seg got %b want 1111111", o_seg); end
        n_vec++; if (o_digit_idx !== 2'd0) begin n_err++; $display("FAIL rst_mid_idx got %0d want 0", o_digit_idx); end
        m_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL rst_mid got %b want %b", obs, exp_vec); end
            if (i == BC + 1) begin
                n_vec++;
                if ({o_an, o_seg} !== {4'b1110, 7'b0000001}) begin
                    n_err++; $display("FAIL rst_mid_zero got %b_%b want 1110_0000001", o_an, o_seg);
                end
            end
        end
    endtask

    task automatic test_lzs();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            value = vals[v]; blank = '0; dp = '0; load = 1'b1;
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL lzs got %b want %b", obs, exp_vec); end
            load = 1'b0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                step();
                n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL lzs got %b want %b", obs, exp_vec); end
`ifdef HEX_7SEG_LZS_EN
                if (i >= FRAME) begin
                    n_vec++;
                    if (o_an === 4'b0111 || o_an === 4'b1011 || (v == 1 && o_an === 4'b1101)) begin
                        n_err++; $display("FAIL lzs_dark got %b want leading digits dark", o_an);
                    end
                end
`endif
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en    = ($urandom_range(0, 39) != 0);
            load  = ($urandom_range(0, 11) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL random cyc=%0d got %b want %b", i, obs, exp_vec); end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe_load();
        test_blank_dp();
        test_load_on_tick();
        test_reset_mid_drive();
        test_lzs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
